// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit and its lane aligner.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    localparam int unsigned MEM_BYTES_DEFAULT = 1024;

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // byte offset 0 is the most significant byte of the word
        case (offset)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[15:0] : word[31:16];

        load_data = word;
        merged    = word;
        case (size)
            SZ_BYTE: begin
                load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                case (offset)
                    2'd0:    merged[31:24] = wdata[7:0];
                    2'd1:    merged[23:16] = wdata[7:0];
                    2'd2:    merged[15:8]  = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                if (offset[1]) merged[15:0]  = wdata;
                else           merged[31:16] = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with read-modify-write for byte/half stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_readEn,
    output logic        mem_writeEn,
    output logic [31:0] mem_address,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout
);

    state_e      state_q, state_n;
    size_e       size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wbuf_q;
    logic        req_err;
    logic        rd_en, wr_en;
    logic [31:0] load_data, merged;

    always_comb begin
        case (size_e'(req_size))
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = |req_addr[1:0];
            SZ_ILL:  req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (req_addr >= MEM_BYTES) req_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                         state_n = ST_RESP;
                    else if (!req_we)                    state_n = ST_LOAD;
                    else if (size_e'(req_size) == SZ_WORD) state_n = ST_WRITE;
                    else                                 state_n = ST_RMW_READ;
                end
            end
            ST_LOAD: begin
                rd_en   = 1'b1;
                state_n = ST_RESP;
            end
            ST_RMW_READ: begin
                rd_en   = 1'b1;
                state_n = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en   = 1'b1;
                state_n = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // wbuf_q holds the raw store data until RMW_READ replaces it with the merged word
    always_ff @(posedge clk) begin
        if (!rstn) begin
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wbuf_q    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        size_q    <= size_e'(req_size);
                        uns_q     <= req_unsigned;
                        addr_q    <= req_addr;
                        wbuf_q    <= req_wdata;
                        rsp_rdata <= '0;
                        rsp_err   <= req_err;
                    end
                end
                ST_LOAD:     rsp_rdata <= load_data;
                ST_RMW_READ: wbuf_q    <= merged;
                default: ;
            endcase
        end
    end

    lsu_lane_align u_align (
        .word        (mem_dataout),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wbuf_q[15:0]),
        .load_data   (load_data),
        .merged      (merged)
    );

    assign mem_readEn  = rd_en & rstn;
    assign mem_writeEn = wr_en & rstn;
    assign mem_address = {addr_q[31:2], 2'b00};
    assign mem_datain  = wbuf_q;

endmodule
